// File: rtl/bsg_fpu_normalize_pipe_pkg.sv
// Shared FPU normalizer definitions: width helpers and the S2 payload struct
// that the rounding stages also consume.
package bsg_fpu_normalize_pipe_pkg;

    // The payload struct is sized by these; the pipe is built at the same widths.
    localparam int fpu_mant_width_lp = 16;
    localparam int fpu_exp_width_lp  = 8;

    function automatic int lg_width(input int width);
        return $clog2(width);
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    typedef struct packed {
        logic [fpu_mant_width_lp-1:0] mant;
        logic [fpu_exp_width_lp-1:0]  exp;
        logic                         zero;
        logic                         denorm;
    } fpu_norm_s;

endpackage

// File: rtl/bsg_fpu_normalize_pipe_if.sv
// Producer/consumer handshake bundle of the normalizer pipe.
// Input side transfers on v_i & ready_o; output side pops on yumi_i, which may
// only be raised while v_o is high; ready_o is the one signal combinational on yumi_i.
interface bsg_fpu_normalize_pipe_if #(
    parameter int width_p     = 16,
    parameter int exp_width_p = 8
);
    logic                   v_i;
    logic                   ready_o;
    logic [width_p-1:0]     mant_i;
    logic [exp_width_p-1:0] exp_i;
    logic                   v_o;
    logic                   yumi_i;
    logic [width_p-1:0]     mant_o;
    logic [exp_width_p-1:0] exp_o;
    logic                   zero_o;
    logic                   denorm_o;

    modport master (
        output v_i, mant_i, exp_i, yumi_i,
        input  ready_o, v_o, mant_o, exp_o, zero_o, denorm_o
    );

    modport slave (
        input  v_i, mant_i, exp_i, yumi_i,
        output ready_o, v_o, mant_o, exp_o, zero_o, denorm_o
    );
endinterface

// File: rtl/bsg_fpu_clz.sv
// Leading-zero counter; result for an all-zero input is don't-care (reads 0).
module bsg_fpu_clz
    import bsg_fpu_normalize_pipe_pkg::*;
#(
    parameter int width_p = 16
) (
    input  logic [width_p-1:0]           mant_i,
    output logic [lg_width(width_p)-1:0] clz_o
);
    localparam int lg_width_lp = lg_width(width_p);

    // Ascending scan so the highest set bit is the last to write.
    always_comb begin
        clz_o = '0;
        for (int i = 0; i < width_p; i++) begin
            if (mant_i[i]) clz_o = lg_width_lp'(width_p - 1 - i);
        end
    end
endmodule

// File: rtl/bsg_fpu_normalize_pipe.sv
// Two-stage normalizer: left-justifies the mantissa, reducing the exponent by
// the shift, clamped at zero exponent so small values become denormals.
module bsg_fpu_normalize_pipe
    import bsg_fpu_normalize_pipe_pkg::*;
#(
    parameter int width_p     = 16,
    parameter int exp_width_p = 8
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    bsg_fpu_normalize_pipe_if.slave   io
);
    localparam int lg_width_lp  = lg_width(width_p);
    localparam int cmp_width_lp = max_int(exp_width_p, lg_width_lp);

    logic                    s1_v, s2_v;
    logic [width_p-1:0]      s1_mant;
    logic [exp_width_p-1:0]  s1_exp;
    fpu_norm_s               s2_r, s2_n;

    logic [lg_width_lp-1:0]  clz;
    logic [cmp_width_lp-1:0] clz_ext, exp_ext, sh;
    logic                    s1_zero, clamp;
    logic                    s2_adv, in_xfer;

    bsg_fpu_clz #(.width_p(width_p)) clz_u (
        .mant_i (s1_mant),
        .clz_o  (clz)
    );

    assign s1_zero = (s1_mant == '0);
    assign clz_ext = cmp_width_lp'(clz);
    assign exp_ext = cmp_width_lp'(s1_exp);
    assign clamp   = (clz_ext > exp_ext);
    assign sh      = clamp ? exp_ext : clz_ext;

    // sh never exceeds the exponent, so the subtraction cannot wrap.
    always_comb begin
        s2_n        = '0;
        s2_n.mant   = s1_mant << sh;
        s2_n.exp    = s1_zero ? '0 : exp_width_p'(exp_ext - sh);
        s2_n.zero   = s1_zero;
        s2_n.denorm = !s1_zero & clamp;
    end

    assign s2_adv     = s1_v & (!s2_v | io.yumi_i);
    assign io.ready_o = !s1_v | s2_adv;
    assign in_xfer    = io.v_i & io.ready_o;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            s1_v    <= 1'b0;
            s2_v    <= 1'b0;
            s1_mant <= '0;
            s1_exp  <= '0;
            s2_r    <= '0;
        end else begin
            if (in_xfer) begin
                s1_v    <= 1'b1;
                s1_mant <= io.mant_i;
                s1_exp  <= io.exp_i;
            end else if (s2_adv) begin
                s1_v <= 1'b0;
            end
            if (s2_adv) begin
                s2_v <= 1'b1;
                s2_r <= s2_n;
            end else if (io.yumi_i) begin
                s2_v <= 1'b0;
            end
        end
    end

    assign io.v_o      = s2_v;
    assign io.mant_o   = s2_r.mant;
    assign io.exp_o    = s2_r.exp;
    assign io.zero_o   = s2_r.zero;
    assign io.denorm_o = s2_r.denorm;
endmodule

// File: tb/tb_bsg_fpu_normalize_pipe.sv
// Directed and randomized checks of the normalizer pipe against hand values
// and an independent shift-loop reference model.
module tb_bsg_fpu_normalize_pipe;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;
    logic [25:0] exp_q[$];

    always #5 clk = ~clk;

    bsg_fpu_normalize_pipe_if #(.width_p(16), .exp_width_p(8)) nif ();

    bsg_fpu_normalize_pipe #(.width_p(16), .exp_width_p(8)) dut (
        .clk_i   (clk),
        .reset_i (rst),
        .io      (nif.slave)
    );

    always @(posedge clk) begin
        if (!rst && nif.yumi_i) begin
            assert (nif.v_o === 1'b1) else begin
                fails++;
                $error("FAIL protocol: yumi_i high while v_o=%0b", nif.v_o);
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [25:0] model(input logic [15:0] m, input logic [7:0] e);
        if (m == 16'h0) return {16'h0, 8'h0, 1'b1, 1'b0};
        while (!m[15] && e != 8'd0) begin
            m = m << 1;
            e = e - 8'd1;
        end
        return {m, e, 1'b0, !m[15]};
    endfunction

    task automatic drive(input logic v, input logic [15:0] m, input logic [7:0] e, input logic y);
        nif.v_i    = v;
        nif.mant_i = m;
        nif.exp_i  = e;
        nif.yumi_i = y;
    endtask

    task automatic check_out(input string tag, input logic [15:0] em, input logic [7:0] ee,
                             input logic ez, input logic ed);
        check({tag, ".v_o"},      nif.v_o, 1);
        check({tag, ".mant_o"},   nif.mant_o, em);
        check({tag, ".exp_o"},    nif.exp_o, ee);
        check({tag, ".zero_o"},   nif.zero_o, ez);
        check({tag, ".denorm_o"}, nif.denorm_o, ed);
    endtask

    // One isolated transfer through an empty pipe, then popped.
    task automatic send_one(input string tag, input logic [15:0] m, input logic [7:0] e,
                            input logic [15:0] em, input logic [7:0] ee,
                            input logic ez, input logic ed);
        @(negedge clk);
        drive(1'b1, m, e, 1'b0);
        #1 check({tag, ".ready"}, nif.ready_o, 1);
        @(negedge clk);
        drive(1'b0, 16'h0, 8'h0, 1'b0);
        check({tag, ".lat1_v_o"}, nif.v_o, 0);
        @(negedge clk);
        check_out(tag, em, ee, ez, ed);
        nif.yumi_i = 1'b1;
        @(negedge clk);
        nif.yumi_i = 1'b0;
        check({tag, ".popped_v_o"}, nif.v_o, 0);
    endtask

    initial begin
        logic [15:0] rm;
        logic [7:0]  re;

        drive(1'b0, 16'h0, 8'h0, 1'b0);
        @(negedge clk);
        check("rst.v_o", nif.v_o, 0);
        check("rst.ready_o", nif.ready_o, 1);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("post_rst.v_o", nif.v_o, 0);
        check("post_rst.data", {nif.mant_o, nif.exp_o, nif.zero_o, nif.denorm_o}, 0);
        check("post_rst.ready_o", nif.ready_o, 1);

        send_one("v1",   16'h0001, 8'd20, 16'h8000, 8'd5,  1'b0, 1'b0);
        send_one("v2",   16'h0F00, 8'd2,  16'h3C00, 8'd0,  1'b0, 1'b1);
        send_one("zero", 16'h0000, 8'd77, 16'h0000, 8'd0,  1'b1, 1'b0);
        send_one("norm", 16'h8123, 8'd9,  16'h8123, 8'd9,  1'b0, 1'b0);
        send_one("exp0", 16'h0040, 8'd0,  16'h0040, 8'd0,  1'b0, 1'b1);
        send_one("cz_eq_exp", 16'h0100, 8'd7, 16'h8000, 8'd0, 1'b0, 1'b0);

        // Back-pressure: A, B fill the pipe, C is stalled until the first pop.
        @(negedge clk);
        drive(1'b1, 16'h0001, 8'd20, 1'b0);
        #1 check("bp.ready_a", nif.ready_o, 1);
        @(negedge clk);
        drive(1'b1, 16'h0F00, 8'd2, 1'b0);
        #1 check("bp.ready_b", nif.ready_o, 1);
        @(negedge clk);
        drive(1'b1, 16'h00F0, 8'd10, 1'b0);
        #1 check("bp.ready_full", nif.ready_o, 0);
        @(negedge clk);
        check("bp.still_full", nif.ready_o, 0);
        nif.yumi_i = 1'b1;
        #1 check("bp.ready_on_pop", nif.ready_o, 1);
        check_out("bp.a", 16'h8000, 8'd5, 1'b0, 1'b0);
        @(negedge clk);
        nif.v_i = 1'b0;
        check_out("bp.b", 16'h3C00, 8'd0, 1'b0, 1'b1);
        @(negedge clk);
        check_out("bp.c", 16'hF000, 8'd2, 1'b0, 1'b0);
        @(negedge clk);
        nif.yumi_i = 1'b0;
        check("bp.empty", nif.v_o, 0);

        // Random streaming against the reference model.
        for (int c = 0; c < 10000; c++) begin
            @(negedge clk);
            rm = 16'($urandom_range(0, 65535) >> $urandom_range(0, 16));
            re = 8'($urandom_range(0, 20));
            drive(1'($urandom_range(0, 1)), rm, re,
                  nif.v_o && ($urandom_range(0, 3) != 0));
            #1;
            if (nif.yumi_i) begin
                if (exp_q.size() == 0) check("rand.unexpected_pop", 1, 0);
                else check("rand.out", {nif.mant_o, nif.exp_o, nif.zero_o, nif.denorm_o},
                           32'(exp_q.pop_front()));
            end
            if (nif.v_i && nif.ready_o) exp_q.push_back(model(rm, re));
        end
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            drive(1'b0, 16'h0, 8'h0, nif.v_o);
            #1;
            if (nif.yumi_i) begin
                if (exp_q.size() == 0) check("drain.unexpected_pop", 1, 0);
                else check("drain.out", {nif.mant_o, nif.exp_o, nif.zero_o, nif.denorm_o},
                           32'(exp_q.pop_front()));
            end
        end
        check("drain.left", exp_q.size(), 0);
        @(negedge clk);
        drive(1'b0, 16'h0, 8'h0, 1'b0);

        // Mid-stream asynchronous reset with both stages full.
        @(negedge clk);
        drive(1'b1, 16'h0001, 8'd20, 1'b0);
        @(negedge clk);
        drive(1'b1, 16'h0F00, 8'd2, 1'b0);
        @(negedge clk);
        nif.v_i = 1'b0;
        check("mrst.full_v_o", nif.v_o, 1);
        check("mrst.full_ready", nif.ready_o, 0);
        #2 rst = 1'b1;
        #1;
        check("mrst.v_o", nif.v_o, 0);
        check("mrst.data", {nif.mant_o, nif.exp_o, nif.zero_o, nif.denorm_o}, 0);
        check("mrst.ready_o", nif.ready_o, 1);
        @(negedge clk);
        rst = 1'b0;
        drive(1'b1, 16'h0F00, 8'd2, 1'b0);
        #1 check("mrst.first_ready", nif.ready_o, 1);
        @(negedge clk);
        nif.v_i = 1'b0;
        check("mrst.lat1_v_o", nif.v_o, 0);
        @(negedge clk);
        check_out("mrst.first", 16'h3C00, 8'd0, 1'b0, 1'b1);
        nif.yumi_i = 1'b1;
        @(negedge clk);
        nif.yumi_i = 1'b0;
        check("mrst.only_one", nif.v_o, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/bsg_fpu_normalize_pipe.md
# bsg_fpu_normalize_pipe

Two-stage pipelined normalizer for the FPU datapath. It sits directly downstream of the leading-zero counter `bsg_fpu_clz`. It takes an unnormalized unsigned mantissa with a biased exponent and left-shifts the mantissa until its MSB is one. The exponent is reduced by the same amount, and the shift is clamped so the exponent never goes below zero, which gives gradual underflow to denormals. Consumers are the rounding and packing stages of the add, multiply and int-to-float paths.

## Interface
Parameters:
- `width_p`, 16, mantissa width; power of two, at least 4.
- `exp_width_p`, 8, biased exponent width.
- `lg_width_lp`, `$clog2(width_p)`, derived; not overridable.

Ports:
- `clk_i` in 1: the single clock.
- `reset_i` in 1: asynchronous, active-high reset.
- `v_i` in 1: input valid.
- `ready_o` out 1: input ready; a transfer occurs when `v_i & ready_o`.
- `mant_i` in `width_p`: unnormalized mantissa.
- `exp_i` in `exp_width_p`: biased exponent of `mant_i`.
- `v_o` out 1: output valid.
- `yumi_i` in 1: consumer accepts the output; legal only while `v_o` is high.
- `mant_o` out `width_p`: normalized mantissa.
- `exp_o` out `exp_width_p`: adjusted exponent.
- `zero_o` out 1: input mantissa was zero.
- `denorm_o` out 1: the shift was clamped by the exponent, so the result is denormal.

## Operation
- **Stage 1 (S1) register** captures `mant_i` and `exp_i` on an input transfer. Combinationally from the S1 contents:
  - `clz` is computed by `bsg_fpu_clz`.
  - `zero = (mant == 0)`. The `clz` value for a zero mantissa is don't-care.
- **Shift amount:** `sh = (clz > exp) ? exp : clz`.
  - The comparison uses `clz` zero-extended to `exp_width_p`.
  - If `exp_width_p < lg_width_lp`, the comparison is done at `lg_width_lp` width.
- **Stage 2 (S2) register** captures the following from S1:
  - `mant << sh`, truncated to `width_p` bits.
  - `exp - sh`, which never underflows.
  - `zero`.
  - `denorm = !zero & (clz > exp)`.
- **Zero case:** `mant_o = 0`, `exp_o = 0`, `zero_o = 1`, `denorm_o = 0`, regardless of `exp_i`.
- **Already-normalized input** (`mant_i[width_p-1] = 1`): passes through unchanged with `denorm_o = 0`.
- **`exp_i = 0` with a nonzero mantissa:** `sh = 0`, output equals input, and `denorm_o = 1` only if `mant_i[width_p-1] = 0`.
- **Pipeline control:** each stage holds one valid bit (`s1_v`, `s2_v`).
  - `s2_adv = s1_v & (!s2_v | yumi_i)`.
  - `ready_o = !s1_v | s2_adv`.
  - The pipeline collapses bubbles: a full pipeline with `yumi_i` high accepts a new input in the same cycle.
- **Registers:** data registers load only on their stage's advance. They are never cleared by a handshake; only `reset_i` clears them.
- **No combinational path** from `yumi_i` to any data output. `ready_o` depends combinationally on `yumi_i`; this is the only such path.

## Timing
- **Latency:** 2 cycles from input transfer to `v_o`, with no back-pressure. Throughput is 1 per cycle.
- **Capacity:** 2 entries. With `yumi_i` held low, exactly two transfers are accepted, then `ready_o` goes low.
- **Outputs:** all outputs except `ready_o` come straight from flops.
- **Reset:**
  - Asserting `reset_i` at any time, including mid-stream, immediately clears `s1_v`, `s2_v` and all data registers. In-flight entries are discarded.
  - During and immediately after reset: `v_o = 0`, `mant_o = 0`, `exp_o = 0`, `zero_o = 0`, `denorm_o = 0`, `ready_o = 1`.
  - The first transfer is possible in the first cycle after deassertion.
- **Simultaneous events:** an S1→S2 advance and a new input transfer in the same cycle are both taken. An output consumption and an S1→S2 advance in the same cycle are both taken.
- **Protocol violation:** `yumi_i` high while `v_o` is low is illegal. Behaviour is undefined; the testbench asserts on it.

## Structure
- **Shared FPU package:** holds the `lg_width_lp` derivation helper and a packed struct `{mant, exp, zero, denorm}` for the S2 payload. Rounding stages reuse this struct.
- **Sub-module:** exactly one, `bsg_fpu_clz` (`width_p`), instantiated on the S1 mantissa. The shift and clamp logic stays inline.
- **Estimated size:** 150–200 lines.

## Test plan
Defaults `width_p = 16`, `exp_width_p = 8`; inputs written as mantissa / exponent.
- `0x0001` / 20 → `mant_o 0x8000`, `exp_o 5`, `zero_o 0`, `denorm_o 0`; `v_o` rises 2 cycles after the transfer.
- `0x0F00` / 2 → `sh = 2`: `mant_o 0x3C00`, `exp_o 0`, `denorm_o 1`.
- `0x0000` / 77 → `mant_o 0`, `exp_o 0`, `zero_o 1`, `denorm_o 0`. Also `0x8123` / 9 → passes through unchanged, `denorm_o 0`.
- Back-pressure: `yumi_i = 0`, feed 3 vectors back to back → `ready_o` low after 2 transfers. Raise `yumi_i` for 3 cycles → outputs appear in order, with the 3rd accepted in the same cycle as the first pop.
- Random streaming: random `v_i`/`yumi_i` over 10k cycles. Compare against a reference model with a scoreboard; no loss, duplication or reordering.
- Reset mid-stream with both stages full → `v_o = 0` and all outputs 0 immediately (asynchronous). `ready_o = 1`. The first post-reset vector emerges after 2 cycles.
